// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and bit positions for the SD card SPI master
//
// Contents:
//   spi_state_t      : transfer FSM state (IDLE, LOW, HIGH)
//   ST_* localparams : bit positions inside the status register
//   CT_* localparams : bit positions inside the control register
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } spi_state_t;

   localparam int ST_BUSY = 7;
   localparam int ST_OVR  = 6;
   localparam int ST_DET  = 5;
   localparam int ST_DONE = 4;
   localparam int ST_SSEL = 1;
   localparam int ST_FAST = 0;

   localparam int CT_FAST = 0;
   localparam int CT_SSEL = 1;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// rtl/sd_spi_clkdiv.sv - loadable half-period counter for the SPI clock phases
//
// Ports:
//   phi        : system clock
//   reset      : asynchronous, active-high reset
//   run        : counter advances only while a transfer is in progress
//   clear      : forces the count back to 0 (transfer start)
//   div        : half-period length minus 1, in phi cycles
//   phase_tick : high in the last cycle of a phase (count == div)
module sd_spi_clkdiv #(
   parameter int DIV_W = 8
) (
   input  logic             phi,
   input  logic             reset,
   input  logic             run,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             phase_tick
);

   logic [DIV_W-1:0] cnt;

   assign phase_tick = run && (cnt == div);

   // The count restarts at every phase change so each phase is exactly div+1 cycles.
   always_ff @(posedge phi or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || !run || phase_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sd_spi_ctrl.sv
// rtl/sd_spi_ctrl.sv - byte-oriented SPI mode 0 master driving the SD card pins
//
// Ports:
//   phi            : system clock
//   reset          : asynchronous, active-high reset
//   wr_data_tick   : din is a byte to transmit
//   wr_ctrl_tick   : din is a control value {.., ssel, fast}
//   rd_status_tick : status was read; clears done and overrun
//   din            : CPU write data
//   sd_miso        : card data out
//   sd_det         : card detect, passed straight into status
//   rx_data        : last fully received byte
//   status         : {busy, overrun, sd_det, done, 2'b0, ssel, fast}
//   irq            : level interrupt, mirrors done
//   sd_mosi        : card data in
//   sd_clk         : SPI clock, idle low
//   sd_ssel_n      : card select, active low
module sd_spi_ctrl
   import sd_spi_pkg::*;
#(
   parameter int DIV_SLOW = 23,
   parameter int DIV_FAST = 0,
   parameter int DIV_W    = 8
) (
   input  logic       phi,
   input  logic       reset,
   input  logic       wr_data_tick,
   input  logic       wr_ctrl_tick,
   input  logic       rd_status_tick,
   input  logic [7:0] din,
   input  logic       sd_miso,
   input  logic       sd_det,
   output logic [7:0] rx_data,
   output logic [7:0] status,
   output logic       irq,
   output logic       sd_mosi,
   output logic       sd_clk,
   output logic       sd_ssel_n
);

   spi_state_t       state_q, state_d;
   logic [7:0]       tx_sr, rx_sr;
   logic [2:0]       bit_cnt;
   logic [DIV_W-1:0] div_q;
   logic             fast_q, ssel_q, done_q, ovr_q;
   logic             busy, start, ctrl_ok, ovr_set, new_fast, phase_tick, xfer_done;

   assign busy      = (state_q != IDLE);
   assign start     = wr_data_tick && !busy;
   assign ctrl_ok   = wr_ctrl_tick && !busy;
   assign ovr_set   = busy && (wr_data_tick || wr_ctrl_tick);
   // A control write in the same cycle as a start must pick the divider for that transfer.
   assign new_fast  = ctrl_ok ? din[CT_FAST] : fast_q;
   assign xfer_done = (state_q == HIGH) && phase_tick && (bit_cnt == 3'd7);

   sd_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
      .phi        (phi),
      .reset      (reset),
      .run        (busy),
      .clear      (start),
      .div        (div_q),
      .phase_tick (phase_tick)
   );

   always_ff @(posedge phi or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sd_clk  = 1'b0;
      sd_mosi = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOW;
         end
         LOW: begin
            sd_mosi = tx_sr[7];
            if (phase_tick) state_d = HIGH;
         end
         HIGH: begin
            sd_clk  = 1'b1;
            sd_mosi = tx_sr[7];
            if (phase_tick) state_d = (bit_cnt == 3'd7) ? IDLE : LOW;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge phi or posedge reset) begin
      if (reset) begin
         tx_sr   <= 8'h00;
         rx_sr   <= 8'h00;
         rx_data <= 8'h00;
         bit_cnt <= 3'd0;
         div_q   <= '0;
         fast_q  <= 1'b0;
         ssel_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (ctrl_ok) begin
            fast_q <= din[CT_FAST];
            ssel_q <= din[CT_SSEL];
         end
         if (start) begin
            tx_sr   <= din;
            bit_cnt <= 3'd0;
            div_q   <= new_fast ? DIV_W'(DIV_FAST) : DIV_W'(DIV_SLOW);
         end
         // LOW exit is the edge that raises sd_clk: capture miso there.
         if (state_q == LOW && phase_tick) begin
            rx_sr <= {rx_sr[6:0], sd_miso};
         end
         // HIGH exit: next bit onto mosi; bit_cnt wraps 7->0 only on the final exit.
         if (state_q == HIGH && phase_tick) begin
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (xfer_done) begin
            rx_data <= rx_sr;
         end
         // Set wins over clear for both sticky flags.
         if (xfer_done) begin
            done_q <= 1'b1;
         end else if (start || rd_status_tick) begin
            done_q <= 1'b0;
         end
         if (ovr_set) begin
            ovr_q <= 1'b1;
         end else if (rd_status_tick) begin
            ovr_q <= 1'b0;
         end
      end
   end

   always_comb begin
      status          = 8'h00;
      status[ST_BUSY] = busy;
      status[ST_OVR]  = ovr_q;
      status[ST_DET]  = sd_det;
      status[ST_DONE] = done_q;
      status[ST_SSEL] = ssel_q;
      status[ST_FAST] = fast_q;
   end

   assign irq       = done_q;
   assign sd_ssel_n = ~ssel_q;

endmodule
